// File: rtl/wb_stage_pipe_if.sv
// Bundle of handshake, load-format, memory-response and register-file write signals for wb_stage_pipe.
// The misalign_o signal exists only when WB_MISALIGN_CHK_EN is defined.
interface wb_stage_pipe_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int OFF_W  = $clog2(XLEN/8)
);
   logic              in_valid_i;
   logic              in_ready_o;
   logic              reg_write_i;
   logic              is_load_i;
   logic [2:0]        ld_fmt_i;
   logic [REG_AW-1:0] rd_i;
   logic [XLEN-1:0]   alu_data_i;
   logic [OFF_W-1:0]  addr_off_i;
   logic              dmem_valid_i;
   logic [XLEN-1:0]   dmem_data_i;
   logic              rf_we_o;
   logic [REG_AW-1:0] rf_waddr_o;
   logic [XLEN-1:0]   w_data_o;
   logic              busy_o;
   logic              timeout_o;
`ifdef WB_MISALIGN_CHK_EN
   logic              misalign_o;
`endif

   // Upstream stage, data memory and register file together form the master side.
   modport master (
      output in_valid_i, reg_write_i, is_load_i, ld_fmt_i, rd_i, alu_data_i,
             addr_off_i, dmem_valid_i, dmem_data_i,
`ifdef WB_MISALIGN_CHK_EN
      input  misalign_o,
`endif
      input  in_ready_o, rf_we_o, rf_waddr_o, w_data_o, busy_o, timeout_o
   );

   modport slave (
      input  in_valid_i, reg_write_i, is_load_i, ld_fmt_i, rd_i, alu_data_i,
             addr_off_i, dmem_valid_i, dmem_data_i,
`ifdef WB_MISALIGN_CHK_EN
      output misalign_o,
`endif
      output in_ready_o, rf_we_o, rf_waddr_o, w_data_o, busy_o, timeout_o
   );
endinterface

// File: rtl/wb_stage_pipe.sv
// Writeback stage: passes ALU results, waits for and extracts/extends load data, with a load watchdog.
// Optional: define WB_MISALIGN_CHK_EN to drop misaligned loads and pulse misalign_o.
module wb_stage_pipe #(
   parameter int XLEN        = 32,
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input logic            clk,
   input logic            rst,
   wb_stage_pipe_if.slave bus
);
   localparam int OFF_W = $clog2(XLEN/8);

   typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

   state_t            state;
   state_t            state_next;
   logic              accept;
   logic              mem_hit;
   logic              tmo_hit;
   logic              misaligned;
   logic [7:0]        tmo_cnt;
   logic [REG_AW-1:0] rd_q;
   logic              we_q;
   logic [2:0]        fmt_q;
   logic [OFF_W-1:0]  off_q;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   left;
   logic [7:0]        sh_amt;
   logic [XLEN-1:0]   ld_data;

   assign accept        = bus.in_valid_i & (state == IDLE);
   assign bus.in_ready_o = (state == IDLE);
   assign bus.busy_o     = (state != IDLE);
   assign mem_hit       = (state == WAIT_MEM) & bus.dmem_valid_i;
   // A response arriving in the last allowed cycle takes priority over the abort.
   assign tmo_hit       = (state == WAIT_MEM) & ~bus.dmem_valid_i & (tmo_cnt == 8'(MEM_TIMEOUT-1));
   assign bus.timeout_o  = tmo_hit;

`ifdef WB_MISALIGN_CHK_EN
   logic [2:0] align_mask;
   always_comb begin
      align_mask = 3'd0;
      case (bus.ld_fmt_i[1:0])
         2'b01:   align_mask = 3'd1;
         2'b10:   align_mask = 3'd3;
         2'b11:   align_mask = (XLEN == 64) ? 3'd7 : 3'd3;
         default: align_mask = 3'd0;
      endcase
   end
   assign misaligned = |(OFF_W'(align_mask) & bus.addr_off_i);
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!bus.is_load_i)  state_next = WRITE;
               else if (!misaligned) state_next = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            if (mem_hit)      state_next = WRITE;
            else if (tmo_hit) state_next = IDLE;
         end
         WRITE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Shift the field down to bit 0, push it to the top, then shift back arithmetically or logically.
   always_comb begin
      shifted = bus.dmem_data_i >> {off_q, 3'b000};
      case (fmt_q[1:0])
         2'b00:   sh_amt = 8'(XLEN-8);
         2'b01:   sh_amt = 8'(XLEN-16);
         2'b10:   sh_amt = 8'(XLEN-32);
         default: sh_amt = 8'd0;
      endcase
      left = shifted << sh_amt;
      if (fmt_q[2]) ld_data = left >> sh_amt;
      else          ld_data = $signed(left) >>> sh_amt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q           <= '0;
         we_q           <= 1'b0;
         fmt_q          <= 3'd0;
         off_q          <= '0;
         tmo_cnt        <= 8'd0;
         bus.rf_we_o    <= 1'b0;
         bus.rf_waddr_o <= '0;
         bus.w_data_o   <= '0;
`ifdef WB_MISALIGN_CHK_EN
         bus.misalign_o <= 1'b0;
`endif
      end else begin
         bus.rf_we_o <= 1'b0;
`ifdef WB_MISALIGN_CHK_EN
         bus.misalign_o <= accept & bus.is_load_i & misaligned;
`endif
         if (accept) begin
            rd_q    <= bus.rd_i;
            we_q    <= bus.reg_write_i;
            fmt_q   <= bus.ld_fmt_i;
            off_q   <= bus.addr_off_i;
            tmo_cnt <= 8'd0;
            if (!bus.is_load_i) begin
               bus.rf_we_o    <= bus.reg_write_i & (bus.rd_i != '0);
               bus.rf_waddr_o <= bus.rd_i;
               bus.w_data_o   <= bus.alu_data_i;
            end
         end else if (state == WAIT_MEM) begin
            if (mem_hit) begin
               bus.rf_we_o    <= we_q & (rd_q != '0);
               bus.rf_waddr_o <= rd_q;
               bus.w_data_o   <= ld_data;
            end else begin
               tmo_cnt <= tmo_cnt + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: a 32-bit instance (MEM_TIMEOUT=4) and a 64-bit instance,
// with expected register-file writes queued at stimulus time and popped when rf_we_o fires.
module tb_wb_stage_pipe;
   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
   } wr_t;

   typedef struct {
      logic [2:0]  fmt;
      logic [1:0]  off;
      logic [31:0] data;
      logic [31:0] exp;
   } ld32_t;

   typedef struct {
      logic [2:0]  fmt;
      logic [2:0]  off;
      logic [63:0] data;
      logic [63:0] exp;
   } ld64_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;
   wr_t  q32[$];
   wr_t  q64[$];

   always #5 clk = ~clk;

   wb_stage_pipe_if #(.XLEN(32), .REG_AW(5)) a ();
   wb_stage_pipe_if #(.XLEN(64), .REG_AW(5)) b ();

   wb_stage_pipe #(.XLEN(32), .REG_AW(5), .MEM_TIMEOUT(4)) dut32 (.clk(clk), .rst(rst), .bus(a.slave));
   wb_stage_pipe #(.XLEN(64), .REG_AW(5), .MEM_TIMEOUT(15)) dut64 (.clk(clk), .rst(rst), .bus(b.slave));

   // Scoreboard monitors: every write strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      wr_t e;
      if (rst !== 1'b1 && a.rf_we_o === 1'b1) begin
         tests_run++;
         if (q32.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL write32_unexpected: waddr=%0d data=%h, no write expected", a.rf_waddr_o, a.w_data_o);
         end else begin
            e = q32.pop_front();
            if (a.rf_waddr_o !== e.addr || a.w_data_o !== e.data[31:0]) begin
               tests_failed++;
               $display("[TB] FAIL write32: got waddr=%0d data=%h, expected waddr=%0d data=%h",
                        a.rf_waddr_o, a.w_data_o, e.addr, e.data[31:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (rst !== 1'b1 && b.rf_we_o === 1'b1) begin
         tests_run++;
         if (q64.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL write64_unexpected: waddr=%0d data=%h, no write expected", b.rf_waddr_o, b.w_data_o);
         end else begin
            e = q64.pop_front();
            if (b.rf_waddr_o !== e.addr || b.w_data_o !== e.data) begin
               tests_failed++;
               $display("[TB] FAIL write64: got waddr=%0d data=%h, expected waddr=%0d data=%h",
                        b.rf_waddr_o, b.w_data_o, e.addr, e.data);
            end
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one instruction on the 32-bit instance for a single cycle; returns 1 ns after the accept edge.
   task automatic applyStimulus(input logic ld, input logic rw, input logic [2:0] fmt,
                                input logic [4:0] rd, input logic [31:0] alu, input logic [1:0] off);
      a.in_valid_i  = 1'b1;
      a.is_load_i   = ld;
      a.reg_write_i = rw;
      a.ld_fmt_i    = fmt;
      a.rd_i        = rd;
      a.alu_data_i  = alu;
      a.addr_off_i  = off;
      @(posedge clk);
      #1;
      a.in_valid_i = 1'b0;
   endtask

   task automatic memRespond(input logic [31:0] d);
      a.dmem_valid_i = 1'b1;
      a.dmem_data_i  = d;
      @(posedge clk);
      #1;
      a.dmem_valid_i = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      tests_run++;
      if ({a.in_ready_o, a.rf_we_o, a.busy_o, a.timeout_o} !== 4'b1000) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctrl32: got {ready,we,busy,tmo}=%b expected 1000",
                  {a.in_ready_o, a.rf_we_o, a.busy_o, a.timeout_o});
      end
      tests_run++;
      if (a.rf_waddr_o !== 5'd0 || a.w_data_o !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_data32: got waddr=%0d data=%h expected 0/0", a.rf_waddr_o, a.w_data_o);
      end
      tests_run++;
      if ({b.in_ready_o, b.rf_we_o, b.busy_o, b.timeout_o} !== 4'b1000 || b.w_data_o !== 64'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset64: got {ready,we,busy,tmo}=%b data=%h expected 1000/0",
                  {b.in_ready_o, b.rf_we_o, b.busy_o, b.timeout_o}, b.w_data_o);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      waitCycles(1);
   endtask

   task automatic test_alu;
      q32.push_back('{5'd5, 64'hDEADBEEF});
      applyStimulus(1'b0, 1'b1, 3'b000, 5'd5, 32'hDEADBEEF, 2'd0);
      @(negedge clk);
      tests_run++;
      if ({a.rf_we_o, a.in_ready_o} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL alu_strobe: got {we,ready}=%b expected 10", {a.rf_we_o, a.in_ready_o});
      end
      @(negedge clk);
      tests_run++;
      if ({a.rf_we_o, a.in_ready_o, a.w_data_o} !== {2'b01, 32'hDEADBEEF}) begin
         tests_failed++;
         $display("[TB] FAIL alu_release: got {we,ready}=%b data=%h expected 01/deadbeef",
                  {a.rf_we_o, a.in_ready_o}, a.w_data_o);
      end
      waitCycles(1);
   endtask

   task automatic test_load_extract;
      ld32_t tbl[$] = '{
         '{3'b000, 2'd2, 32'h1280_3456, 32'hFFFF_FF80},
         '{3'b100, 2'd2, 32'h1280_3456, 32'h0000_0080},
         '{3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001},
         '{3'b101, 2'd0, 32'h0000_F00D, 32'h0000_F00D},
         '{3'b001, 2'd0, 32'h0000_7FFF, 32'h0000_7FFF},
         '{3'b110, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D},
         '{3'b011, 2'd0, 32'h8000_0001, 32'h8000_0001},
         '{3'b000, 2'd3, 32'hAB00_0000, 32'hFFFF_FFAB}
      };
`ifndef WB_MISALIGN_CHK_EN
      ld32_t wrap_e;
      wrap_e = '{3'b001, 2'd3, 32'hAB00_0000, 32'h0000_00AB};
      tbl.push_back(wrap_e);
`endif
      foreach (tbl[i]) begin
         // A stray response in the accept cycle itself must be ignored.
         a.dmem_valid_i = 1'b1;
         a.dmem_data_i  = 32'h5555_5555;
         applyStimulus(1'b1, 1'b1, tbl[i].fmt, 5'(i + 1), 32'h0, tbl[i].off);
         a.dmem_valid_i = 1'b0;
         @(negedge clk);
         tests_run++;
         if ({a.busy_o, a.rf_we_o, a.in_ready_o} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL load_wait[%0d]: got {busy,we,ready}=%b expected 100",
                     i, {a.busy_o, a.rf_we_o, a.in_ready_o});
         end
         waitCycles(2);
         q32.push_back('{5'(i + 1), {32'h0, tbl[i].exp}});
         memRespond(tbl[i].data);
         @(negedge clk);
         tests_run++;
         if (a.rf_we_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_strobe[%0d]: got we=%b expected 1", i, a.rf_we_o);
         end
         waitCycles(1);
      end
   endtask

   task automatic test_timeout;
      logic [1:0] exp;
      applyStimulus(1'b1, 1'b1, 3'b010, 5'd7, 32'h0, 2'd0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         exp = (k < 4) ? 2'b01 : (k == 4) ? 2'b11 : 2'b00;
         tests_run++;
         if ({a.timeout_o, a.busy_o} !== exp) begin
            tests_failed++;
            $display("[TB] FAIL timeout_cycle%0d: got {tmo,busy}=%b expected %b", k, {a.timeout_o, a.busy_o}, exp);
         end
      end
      tests_run++;
      if (a.in_ready_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_idle: got ready=%b expected 1", a.in_ready_o);
      end
      waitCycles(1);
   endtask

   task automatic test_data_wins;
      applyStimulus(1'b1, 1'b1, 3'b101, 5'd9, 32'h0, 2'd0);
      waitCycles(3);
      q32.push_back('{5'd9, 64'h0000_BEEF});
      a.dmem_valid_i = 1'b1;
      a.dmem_data_i  = 32'h1234_BEEF;
      @(negedge clk);
      tests_run++;
      if (a.timeout_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL data_wins_tmo: got tmo=%b expected 0", a.timeout_o);
      end
      @(posedge clk);
      #1;
      a.dmem_valid_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (a.rf_we_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL data_wins_we: got we=%b expected 1", a.rf_we_o);
      end
      waitCycles(1);
   endtask

   task automatic test_no_write;
      applyStimulus(1'b0, 1'b1, 3'b000, 5'd0, 32'h1234, 2'd0);
      @(negedge clk);
      tests_run++;
      if ({a.rf_we_o, a.busy_o} !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL x0_suppress: got {we,busy}=%b expected 01", {a.rf_we_o, a.busy_o});
      end
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 3'b000, 5'd3, 32'h5678, 2'd0);
      @(negedge clk);
      tests_run++;
      if ({a.rf_we_o, a.busy_o} !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL regwrite0: got {we,busy}=%b expected 01", {a.rf_we_o, a.busy_o});
      end
      waitCycles(1);
   endtask

   task automatic test_back_to_back;
      q32.push_back('{5'd10, 64'hAAAA_0001});
      q32.push_back('{5'd11, 64'hBBBB_0002});
      a.in_valid_i = 1'b1; a.is_load_i = 1'b0; a.reg_write_i = 1'b1;
      a.rd_i = 5'd10; a.alu_data_i = 32'hAAAA_0001;
      @(posedge clk);
      #1;
      a.rd_i = 5'd11; a.alu_data_i = 32'hBBBB_0002;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         tests_run++;
         if (a.rf_we_o !== ((k == 2) ? 1'b0 : 1'b1)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_cycle%0d: got we=%b expected %b", k, a.rf_we_o, (k != 2));
         end
         @(posedge clk);
         #1;
         if (k == 2) a.in_valid_i = 1'b0;
      end
   endtask

   task automatic test_reset_midload;
      applyStimulus(1'b1, 1'b1, 3'b010, 5'd6, 32'h0, 2'd0);
      waitCycles(1);
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({a.in_ready_o, a.rf_we_o, a.busy_o, a.timeout_o} !== 4'b1000 ||
          a.rf_waddr_o !== 5'd0 || a.w_data_o !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL rst_midload: got {ready,we,busy,tmo}=%b waddr=%0d data=%h expected 1000/0/0",
                  {a.in_ready_o, a.rf_we_o, a.busy_o, a.timeout_o}, a.rf_waddr_o, a.w_data_o);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      memRespond(32'hFFFF_FFFF);
      @(negedge clk);
      tests_run++;
      if ({a.rf_we_o, a.busy_o} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL rst_late_resp: got {we,busy}=%b expected 00", {a.rf_we_o, a.busy_o});
      end
      waitCycles(1);
   endtask

   task automatic test_load64;
      ld64_t tbl[$] = '{
         '{3'b110, 3'd4, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321},
         '{3'b010, 3'd4, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321},
         '{3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF},
         '{3'b100, 3'd7, 64'hFE00_0000_0000_0000, 64'h0000_0000_0000_00FE}
      };
      foreach (tbl[i]) begin
         b.in_valid_i = 1'b1; b.is_load_i = 1'b1; b.reg_write_i = 1'b1;
         b.ld_fmt_i = tbl[i].fmt; b.addr_off_i = tbl[i].off; b.rd_i = 5'(i + 20);
         @(posedge clk);
         #1;
         b.in_valid_i = 1'b0;
         q64.push_back('{5'(i + 20), tbl[i].exp});
         b.dmem_valid_i = 1'b1;
         b.dmem_data_i  = tbl[i].data;
         @(posedge clk);
         #1;
         b.dmem_valid_i = 1'b0;
         @(negedge clk);
         tests_run++;
         if (b.rf_we_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load64_strobe[%0d]: got we=%b expected 1", i, b.rf_we_o);
         end
         waitCycles(1);
      end
   endtask

`ifdef WB_MISALIGN_CHK_EN
   task automatic test_misalign;
      applyStimulus(1'b1, 1'b1, 3'b001, 5'd4, 32'h0, 2'd1);
      @(negedge clk);
      tests_run++;
      if ({a.misalign_o, a.busy_o} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL misalign_pulse: got {mis,busy}=%b expected 10", {a.misalign_o, a.busy_o});
      end
      waitCycles(1);
      memRespond(32'h1111_2222);
      @(negedge clk);
      tests_run++;
      if ({a.misalign_o, a.rf_we_o} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL misalign_drop: got {mis,we}=%b expected 00", {a.misalign_o, a.rf_we_o});
      end
      waitCycles(1);
      applyStimulus(1'b1, 1'b1, 3'b001, 5'd4, 32'h0, 2'd2);
      @(negedge clk);
      tests_run++;
      if ({a.misalign_o, a.busy_o} !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL aligned_half: got {mis,busy}=%b expected 01", {a.misalign_o, a.busy_o});
      end
      q32.push_back('{5'd4, 64'hFFFF_9ABC});
      waitCycles(1);
      memRespond(32'h9ABC_0000);
      waitCycles(1);
   endtask
`endif

   initial begin
      a.in_valid_i = 1'b0; a.reg_write_i = 1'b0; a.is_load_i = 1'b0; a.ld_fmt_i = 3'd0;
      a.rd_i = '0; a.alu_data_i = '0; a.addr_off_i = '0; a.dmem_valid_i = 1'b0; a.dmem_data_i = '0;
      b.in_valid_i = 1'b0; b.reg_write_i = 1'b0; b.is_load_i = 1'b0; b.ld_fmt_i = 3'd0;
      b.rd_i = '0; b.alu_data_i = '0; b.addr_off_i = '0; b.dmem_valid_i = 1'b0; b.dmem_data_i = '0;

      test_reset();
      test_alu();
      test_load_extract();
      test_timeout();
      test_data_wins();
      test_no_write();
      test_back_to_back();
      test_reset_midload();
      test_load64();
`ifdef WB_MISALIGN_CHK_EN
      test_misalign();
`endif
      waitCycles(2);
      tests_run++;
      if (q32.size() != 0 || q64.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL writes_missing: got %0d/%0d pending expected writes, required 0/0", q32.size(), q64.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
